// File: rtl/readout_ring_buffer.sv
// Circular readout buffer: pushes from a data source, in-order pops to a readout sequencer.
// Tracks occupancy separately from the pointers and keeps sticky overflow/underflow flags.
module readout_ring_buffer #(
    parameter int unsigned DATBITS   = 24,
    parameter int unsigned ADDBITS   = 8,
    parameter int unsigned OVERWRITE = 0,
    parameter int unsigned AFULL_LVL = 192
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [DATBITS-1:0] wdata,
    input  logic               rd,
    output logic [DATBITS-1:0] rdata,
    output logic               rvalid,
    output logic               empty,
    output logic               full,
    output logic               almost_full,
    output logic [ADDBITS:0]   count,
    output logic               overflow,
    output logic               underflow,
    input  logic               clr_err
);

    localparam int unsigned Depth = 2 ** ADDBITS;
    localparam logic [ADDBITS:0]   FullCnt  = {1'b1, {ADDBITS{1'b0}}};
    localparam logic [ADDBITS:0]   AfullCnt = (ADDBITS + 1)'(AFULL_LVL);
    localparam logic [ADDBITS:0]   CntOne   = (ADDBITS + 1)'(1);
    localparam logic [ADDBITS-1:0] PtrOne   = ADDBITS'(1);

    logic [DATBITS-1:0] mem [Depth];

    logic [ADDBITS-1:0] wptr_q, wptr_d;
    logic [ADDBITS-1:0] rptr_q, rptr_d;
    logic [ADDBITS:0]   count_q, count_d;
    logic [DATBITS-1:0] rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic is_empty, is_full;
    logic pop_ok, push_ok, ovw, ovf_ev, unf_ev, mem_we;

    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == FullCnt);

        pop_ok  = rd & ~is_empty;
        // A pop in the same cycle frees the slot, so push+pop on a full buffer both go through.
        push_ok = we & (~is_full | pop_ok);
        ovf_ev  = we & is_full & ~rd;
        ovw     = ovf_ev & (OVERWRITE != 0);
        unf_ev  = rd & is_empty;
        mem_we  = (push_ok | ovw) & ~rst;

        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        if (push_ok || ovw) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (pop_ok || ovw) begin
            rptr_d = rptr_q + PtrOne;
        end
        if (pop_ok) begin
            rdata_d  = mem[rptr_q];
            rvalid_d = 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntOne;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CntOne;
        end

        ovf_d = (ovf_q & ~clr_err) | ovf_ev;
        unf_d = (unf_q & ~clr_err) | unf_ev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= wdata;
        end
    end

    assign rdata       = rdata_q;
    assign rvalid      = rvalid_q;
    assign count       = count_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_q >= AfullCnt);
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule
